// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter for processed pixel bytes heading back to the host.
// Accepts one byte per valid/ready handshake and shifts it out as a frame of one
// start bit, DATA_WIDTH data bits (LSB first) and one stop bit, each held for
// CLKS_PER_BIT clocks. Every output comes from a flop so the line cannot glitch.
//
// Ports:
//   clk_i    in   system clock, posedge
//   rst_i    in   synchronous active-high reset
//   data_i   in   byte to send, sampled only on the accept edge
//   valid_i  in   upstream has a byte on data_i
//   ready_o  out  block can accept a byte this cycle
//   tx_o     out  serial line, idles high
//   busy_o   out  high while a frame is in flight
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_baud;
    logic [CNT_W-1:0]      w_baud_nxt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [IDX_W-1:0]      w_bit_idx_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  r_ready;
    logic                  w_ready_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  w_baud_done;
    logic                  w_last_bit;

    assign w_baud_done = (r_baud == CNT_LAST);
    assign w_last_bit  = (r_bit_idx == IDX_LAST);

    // State, datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_ready   <= w_ready_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next state plus the values the output flops take at the coming edge.
    // Outputs are computed one edge ahead so tx_o reflects the new state
    // in the very cycle the state changes.
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = 1'b1;
        w_ready_nxt   = 1'b0;
        w_busy_nxt    = 1'b1;

        unique case (r_state)
            S_IDLE: begin
                if (valid_i && r_ready) begin
                    // Accept: restart the baud counter so every frame is aligned to its accept edge
                    w_state_nxt   = S_START;
                    w_shift_nxt   = data_i;
                    w_baud_nxt    = '0;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = 1'b0;
                end else begin
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end

            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_baud_nxt = r_baud + CNT_W'(1);
                end
            end

            S_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[DATA_WIDTH-1:1]};
                    if (w_last_bit) begin
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = S_STOP;
                        w_tx_nxt      = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                        // Next data bit is the one that lands in bit 0 after this shift
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + CNT_W'(1);
                end
            end

            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_baud_nxt = r_baud + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign tx_o    = r_tx;
    assign ready_o = r_ready;
    assign busy_o  = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives a CLKS_PER_BIT=4 and a CLKS_PER_BIT=2 transmitter with the same
// stimulus and compares both every cycle against a frame-timing reference model,
// plus directed checks on frame shape, handshake timing and reset behaviour.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       tx4, rdy4, bsy4;
    logic       tx2, rdy2, bsy2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_edge   = 0;

    // Reference model state, index 0 -> C=4, index 1 -> C=2
    logic       m_act [2] = '{1'b0, 1'b0};
    int         m_e0  [2] = '{0, 0};
    logic [7:0] m_byte[2] = '{8'h00, 8'h00};
    logic       m_tx  [2] = '{1'b1, 1'b1};
    logic       m_rdy [2] = '{1'b1, 1'b1};
    logic       m_bsy [2] = '{1'b0, 1'b0};

    // Observation helpers
    logic prev_rdy [2] = '{1'b1, 1'b1};
    logic prev_tx  [2] = '{1'b1, 1'b1};
    int   low_len  [2] = '{0, 0};
    int   last_low [2] = '{0, 0};
    int   high_len [2] = '{0, 0};
    int   last_high[2] = '{0, 0};
    int   st_prev  [2] = '{0, 0};
    int   st_last  [2] = '{0, 0};

    logic [9:0]  mid4, mid2;
    logic [19:0] raw2;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(4), .DATA_WIDTH(8)) u_dut4 (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (data),
        .valid_i(valid),
        .ready_o(rdy4),
        .tx_o   (tx4),
        .busy_o (bsy4)
    );

    uart_tx #(.CLKS_PER_BIT(2), .DATA_WIDTH(8)) u_dut2 (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (data),
        .valid_i(valid),
        .ready_o(rdy2),
        .tx_o   (tx2),
        .busy_o (bsy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, n_edge, got, exp);
        end
    endtask

    // Frame model: an accepted byte occupies 10*C edges; frame bit k covers
    // samples E0+k*C .. E0+(k+1)*C-1 with bit 0 = start, bits 1..8 = data, 9 = stop.
    task automatic model_edge(input int i);
        int c;
        int k;
        c = (i == 0) ? 4 : 2;
        if (rst) begin
            m_act[i] = 1'b0;
        end else begin
            if (m_act[i] && (n_edge - m_e0[i]) >= 10 * c) m_act[i] = 1'b0;
            if (valid && m_rdy[i]) begin
                m_act[i]  = 1'b1;
                m_e0[i]   = n_edge;
                m_byte[i] = data;
            end
        end
        if (m_act[i]) begin
            k = (n_edge - m_e0[i]) / c;
            if (k == 0)      m_tx[i] = 1'b0;
            else if (k == 9) m_tx[i] = 1'b1;
            else             m_tx[i] = m_byte[i][k-1];
            m_rdy[i] = 1'b0;
            m_bsy[i] = 1'b1;
        end else begin
            m_tx[i]  = 1'b1;
            m_rdy[i] = 1'b1;
            m_bsy[i] = 1'b0;
        end
    endtask

    task automatic observe(input int i, input logic t, input logic r);
        if (!r) begin
            low_len[i]++;
        end else if (!prev_rdy[i]) begin
            last_low[i] = low_len[i];
            low_len[i]  = 0;
        end
        if (prev_rdy[i] && !r) begin
            st_prev[i] = st_last[i];
            st_last[i] = n_edge;
        end
        if (t) begin
            high_len[i]++;
        end else begin
            if (prev_tx[i]) last_high[i] = high_len[i];
            high_len[i] = 0;
        end
        prev_rdy[i] = r;
        prev_tx[i]  = t;
    endtask

    // One clock: model both instances at the edge, compare on the falling edge
    task automatic tick();
        @(posedge clk);
        n_edge++;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check("tx4",  tx4,  m_tx[0]);
        check("rdy4", rdy4, m_rdy[0]);
        check("bsy4", bsy4, m_bsy[0]);
        check("tx2",  tx2,  m_tx[1]);
        check("rdy2", rdy2, m_rdy[1]);
        check("bsy2", bsy2, m_bsy[1]);
        observe(0, tx4, rdy4);
        observe(1, tx2, rdy2);
    endtask

    // Pulse one byte, optionally poke a second valid while busy, capture mid-bit samples
    task automatic run_frame(input logic [7:0] b, input int inj_at, input logic [7:0] inj,
                             output logic [9:0] c4, output logic [9:0] c2, output logic [19:0] r2);
        c4 = '0;
        c2 = '0;
        r2 = '0;
        valid = 1'b1;
        data  = b;
        tick();
        valid = 1'b0;
        for (int j = 0; j < 44; j++) begin
            if ((j % 4) == 2 && j < 40) c4[j/4] = tx4;
            if ((j % 2) == 1 && j < 20) c2[j/2] = tx2;
            if (j < 20) r2[j] = tx2;
            if (j == inj_at) begin
                valid = 1'b1;
                data  = inj;
            end else begin
                valid = 1'b0;
            end
            if (inj_at >= 0 && j == inj_at + 8) data = ~inj;
            tick();
        end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'hFF;
        @(negedge clk);

        // Reset held with valid high: nothing may start
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_tx4",  tx4,  1'b1);
            check("rst_rdy4", rdy4, 1'b1);
            check("rst_bsy4", bsy4, 1'b0);
        end
        rst   = 1'b0;
        valid = 1'b0;
        repeat (5) tick();

        // Single byte 0xA5
        run_frame(8'hA5, -1, 8'h00, mid4, mid2, raw2);
        check("a5_bits4", mid4, 10'b1101001010);
        check("a5_bits2", mid2, 10'b1101001010);
        check("a5_rdylow4", last_low[0], 40);
        check("a5_rdylow2", last_low[1], 20);
        repeat (5) tick();

        // Back-to-back with valid held: 0x00 then 0xFF
        valid = 1'b1;
        data  = 8'h00;
        tick();
        data = 8'hFF;
        repeat (41) tick();
        check("b2b_gap4",  st_last[0] - st_prev[0], 41);
        check("b2b_high4", last_high[0], 5);
        check("b2b_gap2",  st_last[1] - st_prev[1], 21);
        check("b2b_high2", last_high[1], 3);
        valid = 1'b0;
        repeat (60) tick();

        // Valid poked mid-frame plus data_i changing: only 0xC3 goes out
        run_frame(8'hC3, 12, 8'h3C, mid4, mid2, raw2);
        check("busy_bits4", mid4, 10'b1110000110);
        check("busy_bits2", mid2, 10'b1110000110);
        check("busy_rdylow4", last_low[0], 40);
        repeat (5) tick();

        // Reset during data bit 3 of the C=4 frame
        valid = 1'b1;
        data  = 8'h5A;
        tick();
        valid = 1'b0;
        repeat (17) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_tx4",  tx4,  1'b1);
        check("abort_rdy4", rdy4, 1'b1);
        check("abort_bsy4", bsy4, 1'b0);
        run_frame(8'h81, -1, 8'h00, mid4, mid2, raw2);
        check("post_rst_bits4", mid4, 10'b1100000010);
        check("post_rst_bits2", mid2, 10'b1100000010);
        repeat (5) tick();

        // Minimum divider: 0x01 on the C=2 instance, every cycle of the frame
        run_frame(8'h01, -1, 8'h00, mid4, mid2, raw2);
        check("min_frame2", raw2, 20'hC000C);
        check("min_rdylow2", last_low[1], 20);
        repeat (5) tick();

        // Random traffic with occasional resets
        for (int it = 0; it < 2500; it++) begin
            valid = (($urandom % 4) == 0);
            data  = 8'($urandom);
            rst   = (($urandom % 300) == 0);
            tick();
        end
        rst   = 1'b0;
        valid = 1'b0;
        repeat (50) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
